m_unit: RTL and testbench
=========================

// Module: m_unit
// PURPOSE
//  Memory stage of the 5-stage exception-capable MIPS pipeline; consumes the E->M pipeline register.
//  Performs load/store data-memory access, byte-lane store merging, load extension and peripheral bridge access.
//  Detects address exceptions (AdEL/AdES) and reports them to CP0.
//  Registers the M->W pipeline register and squashes it on flush.
// PARAMETERS
//  DM_WORDS   3072         data memory depth in 32-bit words (12 KiB, byte addr 0x0000_0000..0x0000_2FFF)
//  TMR0_BASE  32'h7F00     timer0 register window base (3 words)
//  TMR1_BASE  32'h7F10     timer1 register window base (3 words)
// PORTS
//  Clk               in   1   clock; all state updates on posedge
//  Reset             in   1   synchronous, active-high reset
//  IRM               in   32  instruction in M
//  PC4M              in   32  PC+4 of the instruction in M
//  AOM               in   32  ALU result / effective address
//  RTM               in   32  rt value latched in E
//  ExcCode_M         in   5   [6:2] exception code from earlier stages; 5'h1F = none
//  BD_M              in   1   instruction is in a branch delay slot
//  Forward_RT_M_src  in   1   0: use RTM; 1: use W_RF_WD_OUT as store data
//  W_RF_WD_OUT       in   32  W-stage register-file write data (forward source)
//  IntReq            in   1   CP0 takes interrupt/exception this cycle; flush M
//  PrRD              in   32  bridge read data (timer registers)
//  ExcCode_out       out  5   combinational resolved exception code to CP0 (5'h1F = none)
//  BD_out            out  1   combinational copy of BD_M to CP0
//  PrAddr            out  32  bridge address (= AOM)
//  PrWD              out  32  bridge write data (forwarded rt)
//  PrWE              out  1   bridge write enable (committed sw to timer window)
//  IRW,PC4W,AOW      out  32  M->W pipeline register
//  DRW               out  32  extended load data register
// BEHAVIOUR
//  Decode (opcode IRM[31:26]): lw 23, lh 21, lhu 25, lb 20, lbu 24, sw 2B, sh 29, sb 28 (hex); others = no access.
//  Store data: rt = Forward_RT_M_src ? W_RF_WD_OUT : RTM.
//  Exception resolution, priority high->low:
//   1. ExcCode_M != 5'h1F: pass ExcCode_M unchanged.
//   2. Misaligned: word ops AOM[1:0]!=0, half ops AOM[0]!=0 -> AdEL(4) for loads, AdES(5) for stores.
//   3. Address not in DM range or either timer window -> AdEL/AdES.
//   4. Byte/half op to a timer window -> AdEL/AdES. sw to timer offset 8 (count, read-only) -> AdES.
//   5. Otherwise 5'h1F.
//  Commit = store && ExcCode_out==5'h1F && !IntReq && !Reset.
//  DM write at posedge on commit, index AOM[13:2]: sw full word; sh rt[15:0] into half AOM[1]; sb rt[7:0] into byte AOM[1:0].
//  Other lanes of the word are untouched.
//  PrWE = commit && sw && AOM in a timer window; DM not written in that case.
//  Load read: combinational from DM[AOM[13:2]] or PrRD.
//   lb/lbu/lh/lhu select lane by AOM[1:0]/AOM[1]; sign-extend (lb,lh) or zero-extend (lbu,lhu).
//  Latency: load data is visible on DRW one cycle after the instruction occupies M.
//   Store-then-load to the same address in back-to-back cycles reads the new value.
//  M->W register: on Reset, IntReq or ExcCode_out!=5'h1F, load IRW=PC4W=AOW=DRW=0 next edge.
//   Otherwise load IRM, PC4M, AOM and the extended load data.
//  Reset: all registered outputs 0 and DM cleared to 0 within the reset cycle. Reset mid-store suppresses that write.
//  Simultaneous IntReq and valid store: store suppressed, bubble into W.
//  Non-memory instructions: ExcCode_out = ExcCode_M, no DM/bridge effect, DRW = 0.
// CONFIGURATION
//  DM_WRITE_LOG_EN defined:
//   every committed DM or bridge write executes $display("%d@%h: *%h <= %h", $time, PC4M-4, {AOM[31:2],2'b00}, merged_word).
//   merged_word is the full post-merge word.
//  Undefined: no display; RTL otherwise identical.
// TESTING
//  sw 0x12345678 @0x10, then lw @0x10 -> DRW=0x12345678 one cycle after lw enters M.
//  sb 0xAB @0x11 over 0x12345678, then lb/lbu @0x11 -> word 0x1234AB78; DRW=0xFFFFFFAB / 0x000000AB.
//  lw @0x13 -> ExcCode_out=4, no W writeback (IRW=0). sh @0x3001 -> ExcCode_out=5, DM unchanged.
//  sw @0x7F08 -> ExcCode_out=5, PrWE=0. sw @0x7F04 -> PrWE=1, PrWD=rt. lw @0x7F14 with PrRD=0x55 -> DRW=0x55.
//  ExcCode_M=12 (Ov) on sw @0x3 -> ExcCode_out=12. IntReq=1 with valid sw -> no write, W bubble.
//  Forward_RT_M_src=1, W_RF_WD_OUT=0xCAFEBABE, sw @0x20 -> DM[8]=0xCAFEBABE; with DM_WRITE_LOG_EN the log line matches.

Source files
------------

// File: rtl/m_unit_if.sv
// -----------------------------------------------------------------------------
// m_unit_if -- peripheral bridge bus between the memory stage and the timers.
//
// Signals
//   PrAddr  32  bridge address (byte address of the access)
//   PrWD    32  bridge write data
//   PrWE    1   bridge write enable, one cycle per committed sw
//   PrRD    32  bridge read data returned by the selected timer register
//
// Modports
//   master  memory stage side (drives address/data/enable, samples PrRD)
//   slave   peripheral side (samples address/data/enable, drives PrRD)
// -----------------------------------------------------------------------------
interface m_unit_if;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic        PrWE;
    logic [31:0] PrRD;

    modport master (
        output PrAddr,
        output PrWD,
        output PrWE,
        input  PrRD
    );

    modport slave (
        input  PrAddr,
        input  PrWD,
        input  PrWE,
        output PrRD
    );
endinterface

// File: rtl/m_unit.sv
// -----------------------------------------------------------------------------
// m_unit -- memory stage of the 5-stage exception-capable MIPS pipeline.
//
// Consumes the E->M pipeline register, performs data-memory loads/stores with
// byte-lane merging, extends load data, bridges word accesses to two timer
// register windows, resolves AdEL/AdES for CP0 and registers the M->W stage.
//
// Ports
//   Clk               in   clock, all state on posedge
//   Reset             in   synchronous active-high reset (clears DM and M->W)
//   IRM, PC4M         in   instruction / PC+4 in M
//   AOM               in   effective address
//   RTM               in   rt value latched in E
//   ExcCode_M         in   exception code from earlier stages (5'h1F = none)
//   BD_M              in   branch-delay-slot flag
//   Forward_RT_M_src  in   1: store data comes from W_RF_WD_OUT
//   W_RF_WD_OUT       in   W-stage register-file write data
//   IntReq            in   CP0 takes an interrupt/exception, flush M
//   pr                bus  peripheral bridge (m_unit_if.master)
//   ExcCode_out       out  resolved exception code (combinational)
//   BD_out            out  copy of BD_M
//   IRW, PC4W, AOW    out  M->W pipeline register
//   DRW               out  extended load data register
//
// Build option
//   DM_WRITE_LOG_EN   when defined, every committed DM or bridge write prints
//                     a log line with the PC, word address and merged word.
// -----------------------------------------------------------------------------
module m_unit #(
    parameter int          DM_WORDS  = 3072,
    parameter logic [31:0] TMR0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TMR1_BASE = 32'h0000_7F10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IRM,
    input  logic [31:0] PC4M,
    input  logic [31:0] AOM,
    input  logic [31:0] RTM,
    input  logic [4:0]  ExcCode_M,
    input  logic        BD_M,
    input  logic        Forward_RT_M_src,
    input  logic [31:0] W_RF_WD_OUT,
    input  logic        IntReq,
    m_unit_if.master    pr,
    output logic [4:0]  ExcCode_out,
    output logic        BD_out,
    output logic [31:0] IRW,
    output logic [31:0] PC4W,
    output logic [31:0] AOW,
    output logic [31:0] DRW
);

    localparam logic [4:0]  EXC_NONE = 5'h1F;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_ADES = 5'd5;
    localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);
    localparam logic [31:0] TMR_SPAN = 32'd12;
    localparam logic [31:0] TMR_CNT  = 32'd8;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    // ---------------------------------------------------------------- decode
    logic [5:0] op;
    logic is_lw, is_lh, is_lhu, is_lb, is_lbu, is_sw, is_sh, is_sb;
    logic is_load, is_store, is_word, is_half, is_byte;

    assign op      = IRM[31:26];
    assign is_lw   = (op == OP_LW);
    assign is_lh   = (op == OP_LH);
    assign is_lhu  = (op == OP_LHU);
    assign is_lb   = (op == OP_LB);
    assign is_lbu  = (op == OP_LBU);
    assign is_sw   = (op == OP_SW);
    assign is_sh   = (op == OP_SH);
    assign is_sb   = (op == OP_SB);

    assign is_load  = is_lw | is_lh | is_lhu | is_lb | is_lbu;
    assign is_store = is_sw | is_sh | is_sb;
    assign is_word  = is_lw | is_sw;
    assign is_half  = is_lh | is_lhu | is_sh;
    assign is_byte  = is_lb | is_lbu | is_sb;

    logic [31:0] rt;
    assign rt = Forward_RT_M_src ? W_RF_WD_OUT : RTM;

    // ------------------------------------------------------- address regions
    logic        dm_hit, tmr0_hit, tmr1_hit, tmr_hit;
    logic [31:0] tmr_off;

    assign dm_hit   = (AOM < DM_BYTES);
    assign tmr0_hit = (AOM >= TMR0_BASE) && (AOM < TMR0_BASE + TMR_SPAN);
    assign tmr1_hit = (AOM >= TMR1_BASE) && (AOM < TMR1_BASE + TMR_SPAN);
    assign tmr_hit  = tmr0_hit | tmr1_hit;
    assign tmr_off  = tmr0_hit ? (AOM - TMR0_BASE) : (AOM - TMR1_BASE);

    // ---------------------------------------------------- exception resolve
    logic misalign, bad_region, bad_tmr, addr_exc;

    assign misalign   = (is_word && (AOM[1:0] != 2'b00)) || (is_half && AOM[0]);
    assign bad_region = !(dm_hit || tmr_hit);
    // Timers only accept word accesses; the count register is read-only.
    assign bad_tmr    = tmr_hit && (!is_word || (is_sw && (tmr_off == TMR_CNT)));
    assign addr_exc   = (is_load || is_store) && (misalign || bad_region || bad_tmr);

    always_comb begin
        ExcCode_out = EXC_NONE;
        if (ExcCode_M != EXC_NONE) begin
            ExcCode_out = ExcCode_M;
        end else if (addr_exc) begin
            ExcCode_out = is_load ? EXC_ADEL : EXC_ADES;
        end
    end

    assign BD_out = BD_M;

    logic commit, dm_we, pr_we;
    assign commit = is_store && (ExcCode_out == EXC_NONE) && !IntReq && !Reset;
    // A store that survives exception checks is either DM or a timer word.
    assign dm_we  = commit && !tmr_hit;
    assign pr_we  = commit && is_sw && tmr_hit;

    assign pr.PrAddr = AOM;
    assign pr.PrWD   = rt;
    assign pr.PrWE   = pr_we;

    // ------------------------------------------------------------ data memory
    logic [31:0] dm_q [DM_WORDS];
    logic [11:0] dm_idx;
    logic [31:0] dm_rd;
    logic [31:0] merged_word;

    assign dm_idx = AOM[13:2];
    assign dm_rd  = dm_q[dm_idx];

    always_comb begin
        merged_word = dm_rd;
        if (is_sw) begin
            merged_word = rt;
        end else if (is_sh) begin
            if (AOM[1]) merged_word[31:16] = rt[15:0];
            else        merged_word[15:0]  = rt[15:0];
        end else if (is_sb) begin
            case (AOM[1:0])
                2'd0:    merged_word[7:0]   = rt[7:0];
                2'd1:    merged_word[15:8]  = rt[7:0];
                2'd2:    merged_word[23:16] = rt[7:0];
                default: merged_word[31:24] = rt[7:0];
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm_q[i] <= '0;
            end
        end else if (dm_we) begin
            dm_q[dm_idx] <= merged_word;
        end
    end

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge Clk) begin
        if (commit) begin
            $display("%d@%h: *%h <= %h", $time, PC4M - 32'd4, {AOM[31:2], 2'b00}, merged_word);
        end
    end
`endif

    // ------------------------------------------------------ load extension
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;

    assign rd_word = tmr_hit ? pr.PrRD : dm_rd;
    assign rd_half = AOM[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (AOM[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    always_comb begin
        ld_ext = '0;
        if (is_lw)       ld_ext = rd_word;
        else if (is_lh)  ld_ext = {{16{rd_half[15]}}, rd_half};
        else if (is_lhu) ld_ext = {16'h0000, rd_half};
        else if (is_lb)  ld_ext = {{24{rd_byte[7]}}, rd_byte};
        else if (is_lbu) ld_ext = {24'h000000, rd_byte};
    end

    // ------------------------------------------------------ M->W register
    logic [31:0] irw_q, irw_d, pc4w_q, pc4w_d, aow_q, aow_d, drw_q, drw_d;
    logic        flush;

    assign flush = IntReq || (ExcCode_out != EXC_NONE);

    always_comb begin
        irw_d  = IRM;
        pc4w_d = PC4M;
        aow_d  = AOM;
        drw_d  = ld_ext;
        if (flush) begin
            irw_d  = '0;
            pc4w_d = '0;
            aow_d  = '0;
            drw_d  = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            irw_q  <= '0;
            pc4w_q <= '0;
            aow_q  <= '0;
            drw_q  <= '0;
        end else begin
            irw_q  <= irw_d;
            pc4w_q <= pc4w_d;
            aow_q  <= aow_d;
            drw_q  <= drw_d;
        end
    end

    assign IRW  = irw_q;
    assign PC4W = pc4w_q;
    assign AOW  = aow_q;
    assign DRW  = drw_q;

endmodule

// File: tb/tb_m_unit.sv
module tb_m_unit;

    localparam logic [31:0] LW  = 32'h8C00_0000;
    localparam logic [31:0] LH  = 32'h8400_0000;
    localparam logic [31:0] LHU = 32'h9400_0000;
    localparam logic [31:0] LB  = 32'h8000_0000;
    localparam logic [31:0] LBU = 32'h9000_0000;
    localparam logic [31:0] SW  = 32'hAC00_0000;
    localparam logic [31:0] SH  = 32'hA400_0000;
    localparam logic [31:0] SB  = 32'hA000_0000;
    localparam logic [31:0] ADD = 32'h0000_0020;
    localparam logic [4:0]  NONE = 5'h1F;
    localparam logic [31:0] PRX  = 32'hA5A5_A5A5;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] IRM = '0, PC4M = '0, AOM = '0, RTM = '0, W_RF_WD_OUT = '0;
    logic [4:0]  ExcCode_M = NONE;
    logic        BD_M = 1'b0, Forward_RT_M_src = 1'b0, IntReq = 1'b0;
    logic [4:0]  ExcCode_out;
    logic        BD_out;
    logic [31:0] IRW, PC4W, AOW, DRW;

    m_unit_if pr_if ();

    m_unit dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .IRM              (IRM),
        .PC4M             (PC4M),
        .AOM              (AOM),
        .RTM              (RTM),
        .ExcCode_M        (ExcCode_M),
        .BD_M             (BD_M),
        .Forward_RT_M_src (Forward_RT_M_src),
        .W_RF_WD_OUT      (W_RF_WD_OUT),
        .IntReq           (IntReq),
        .pr               (pr_if.master),
        .ExcCode_out      (ExcCode_out),
        .BD_out           (BD_out),
        .IRW              (IRW),
        .PC4W             (PC4W),
        .AOW              (AOW),
        .DRW              (DRW)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  exc;
        logic        prwe;
        logic [31:0] prwd;
        logic [31:0] praddr;
        logic        bd;
        logic [31:0] irw, pc4w, aow, drw;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;
    logic  m_valid = 1'b0;
    logic [31:0] pc = 32'h0000_3000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One instruction occupies M for one cycle; expected results go to the scoreboard.
    task automatic issue(input string nm, input logic [31:0] ir, input logic [31:0] ao,
                         input logic [31:0] rt, input logic [4:0] excm, input logic fwd,
                         input logic [31:0] wd, input logic irq, input logic rst,
                         input logic [31:0] prrd, input logic [4:0] exp_exc,
                         input logic exp_prwe, input logic [31:0] exp_drw);
        exp_t e;
        logic flush;
        @(negedge Clk);
        pc               = pc + 32'd4;
        IRM              = ir;
        PC4M             = pc;
        AOM              = ao;
        RTM              = rt;
        ExcCode_M        = excm;
        Forward_RT_M_src = fwd;
        W_RF_WD_OUT      = wd;
        IntReq           = irq;
        Reset            = rst;
        pr_if.PrRD       = prrd;
        BD_M             = pc[2];
        m_valid          = 1'b1;
        flush            = rst || irq || (exp_exc != NONE);
        e.exc    = exp_exc;
        e.prwe   = exp_prwe;
        e.prwd   = fwd ? wd : rt;
        e.praddr = ao;
        e.bd     = pc[2];
        e.irw    = flush ? 32'h0 : ir;
        e.pc4w   = flush ? 32'h0 : pc;
        e.aow    = flush ? 32'h0 : ao;
        e.drw    = flush ? 32'h0 : exp_drw;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: combinational outputs mid-cycle, M->W register after the edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge Clk);
            #4;
            if (m_valid && exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk({nm, ".exc"}, {27'h0, ExcCode_out}, {27'h0, e.exc});
                chk({nm, ".prwe"}, {31'h0, pr_if.PrWE}, {31'h0, e.prwe});
                chk({nm, ".praddr"}, pr_if.PrAddr, e.praddr);
                chk({nm, ".bd"}, {31'h0, BD_out}, {31'h0, e.bd});
                if (e.prwe) chk({nm, ".prwd"}, pr_if.PrWD, e.prwd);
                @(posedge Clk);
                #1;
                chk({nm, ".irw"}, IRW, e.irw);
                chk({nm, ".pc4w"}, PC4W, e.pc4w);
                chk({nm, ".aow"}, AOW, e.aow);
                chk({nm, ".drw"}, DRW, e.drw);
            end
        end
    end

    initial begin
        pr_if.PrRD = PRX;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset.irw", IRW, 32'h0);
        chk("reset.pc4w", PC4W, 32'h0);
        chk("reset.aow", AOW, 32'h0);
        chk("reset.drw", DRW, 32'h0);

        //     name          ir   addr          rt            excm  fwd wd            irq  rst  prrd          exc    prwe drw
        issue("sw_10",       SW,  32'h10,   32'h12345678, NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h0);
        issue("lw_10",       LW,  32'h10,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h12345678);
        issue("sb_11",       SB,  32'h11,   32'hFFFFFFAB, NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h0);
        issue("lw_merge",    LW,  32'h10,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h1234AB78);
        issue("lb_11",       LB,  32'h11,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'hFFFFFFAB);
        issue("lbu_11",      LBU, 32'h11,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h000000AB);
        issue("lh_12",       LH,  32'h12,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h00001234);
        issue("lh_10",       LH,  32'h10,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'hFFFFAB78);
        issue("lhu_10",      LHU, 32'h10,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h0000AB78);
        issue("lw_13",       LW,  32'h13,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          5'd4,  0, 32'h0);
        issue("sh_3001",     SH,  32'h3001, 32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          5'd5,  0, 32'h0);
        issue("sh_11_mis",   SH,  32'h11,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          5'd5,  0, 32'h0);
        issue("lw_unch",     LW,  32'h10,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h1234AB78);
        issue("sw_7f08",     SW,  32'h7F08, 32'h1,        NONE, 0, 32'h0,         0, 0, PRX,          5'd5,  0, 32'h0);
        issue("sw_7f04",     SW,  32'h7F04, 32'hDEAD0001, NONE, 0, 32'h0,         0, 0, PRX,          NONE,  1, 32'h0);
        issue("lw_7f14",     LW,  32'h7F14, 32'h0,        NONE, 0, 32'h0,         0, 0, 32'h55,       NONE,  0, 32'h55);
        issue("lw_7f08",     LW,  32'h7F08, 32'h0,        NONE, 0, 32'h0,         0, 0, 32'h99,       NONE,  0, 32'h99);
        issue("lb_7f00",     LB,  32'h7F00, 32'h0,        NONE, 0, 32'h0,         0, 0, 32'h55,       5'd4,  0, 32'h0);
        issue("lw_7f0c",     LW,  32'h7F0C, 32'h0,        NONE, 0, 32'h0,         0, 0, 32'h55,       5'd4,  0, 32'h0);
        issue("ov_sw_3",     SW,  32'h3,    32'h77777777, 5'd12, 0, 32'h0,        0, 0, PRX,          5'd12, 0, 32'h0);
        issue("lw_0",        LW,  32'h0,    32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h0);
        issue("irq_sw",      SW,  32'h10,   32'h11111111, NONE, 0, 32'h0,         1, 0, PRX,          NONE,  0, 32'h0);
        issue("lw_irq",      LW,  32'h10,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h1234AB78);
        issue("fwd_sw_20",   SW,  32'h20,   32'h0,        NONE, 1, 32'hCAFEBABE,  0, 0, PRX,          NONE,  0, 32'h0);
        issue("lw_20",       LW,  32'h20,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'hCAFEBABE);
        issue("sh_22",       SH,  32'h22,   32'h1234BEEF, NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h0);
        issue("sb_23",       SB,  32'h23,   32'h00000077, NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h0);
        issue("lw_20b",      LW,  32'h20,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h77EFBABE);
        issue("lb_22",       LB,  32'h22,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'hFFFFFFEF);
        issue("add",         ADD, 32'h10,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h0);
        issue("add_exc",     ADD, 32'h10,   32'h0,        5'd10, 0, 32'h0,        0, 0, PRX,          5'd10, 0, 32'h0);
        issue("sw_2ffc",     SW,  32'h2FFC, 32'h600DF00D, NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h0);
        issue("lw_2ffc",     LW,  32'h2FFC, 32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h600DF00D);
        issue("lw_3000",     LW,  32'h3000, 32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          5'd4,  0, 32'h0);
        issue("rst_sw_24",   SW,  32'h24,   32'hBAD0BAD0, NONE, 0, 32'h0,         0, 1, PRX,          NONE,  0, 32'h0);
        issue("lw_24_rst",   LW,  32'h24,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h0);
        issue("lw_10_rst",   LW,  32'h10,   32'h0,        NONE, 0, 32'h0,         0, 0, PRX,          NONE,  0, 32'h0);

        @(negedge Clk);
        m_valid = 1'b0;
        IRM     = '0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
